// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, FSM states and sizing helpers for the multiply/divide unit
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  localparam int MDU_WIDTH = 8;

  function automatic int mdu_cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// rtl/mdu_negate.sv - conditional two's-complement negate, modulo 2^WIDTH
module mdu_negate #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);

  assign out = neg ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit with private HI/LO result registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CNT_W = mdu_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mdu_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  mdu_op_e            op_q;
  logic               sign_a, sign_b, dz_q;
  logic [WIDTH-1:0]   a_raw, b_mag_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;

  logic               is_mul;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     add_sum;
  logic               sub_ok;
  logic [WIDTH-1:0]   sub_diff, rem_keep;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_mul = (op_q == MDU_MULTU) || (op_q == MDU_MULT);
  assign busy   = (state != IDLE);

  mdu_negate #(.WIDTH(WIDTH)) u_neg_a (
    .in(src_a), .neg(op[0] & src_a[WIDTH-1]), .out(a_mag)
  );
  mdu_negate #(.WIDTH(WIDTH)) u_neg_b (
    .in(src_b), .neg(op[0] & src_b[WIDTH-1]), .out(b_mag)
  );

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign addend  = acc[0] ? b_mag_q : '0;
  assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

  // Divide: rem already holds the next dividend bit in its LSB; acc low half collects the quotient.
  assign sub_ok   = (rem >= {1'b0, b_mag_q});
  assign sub_diff = rem[WIDTH-1:0] - b_mag_q;
  assign rem_keep = sub_ok ? sub_diff : rem[WIDTH-1:0];

  mdu_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
    .in(acc), .neg(sign_a ^ sign_b), .out(prod_fix)
  );
  mdu_negate #(.WIDTH(WIDTH)) u_neg_quo (
    .in(acc[WIDTH-1:0]), .neg(sign_a ^ sign_b), .out(quo_fix)
  );
  mdu_negate #(.WIDTH(WIDTH)) u_neg_rem (
    .in(rem[WIDTH:1]), .neg(sign_a), .out(rem_fix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      op_q        <= MDU_MULTU;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      dz_q        <= 1'b0;
      a_raw       <= '0;
      b_mag_q     <= '0;
      acc         <= '0;
      rem         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            op_q    <= mdu_op_e'(op);
            sign_a  <= op[0] & src_a[WIDTH-1];
            sign_b  <= op[0] & src_b[WIDTH-1];
            dz_q    <= op[1] & (src_b == '0);
            a_raw   <= src_a;
            b_mag_q <= b_mag;
            if (op[1]) begin
              acc <= {{WIDTH{1'b0}}, a_mag[WIDTH-2:0], 1'b0};
              rem <= {{WIDTH{1'b0}}, a_mag[WIDTH-1]};
            end else begin
              acc <= {{WIDTH{1'b0}}, a_mag};
              rem <= '0;
            end
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (is_mul) begin
            acc <= {add_sum, acc[WIDTH-1:1]};
          end else begin
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], sub_ok};
            rem            <= {rem_keep, acc[WIDTH-1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (is_mul) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (dz_q) begin
            hi          <= a_raw;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] op;
  logic [7:0] src_a, src_b;
  logic       busy, done, div_by_zero;
  logic [7:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {div_by_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [16:0] model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    int          sa, sb, ua, ub, p, q, r;
    logic [31:0] pv, qv, rv;
    sa = $signed(a);
    sb = $signed(b);
    ua = int'(a);
    ub = int'(b);
    case (o)
      2'b00: begin p = ua * ub; pv = p; return {1'b0, pv[15:0]}; end
      2'b01: begin p = sa * sb; pv = p; return {1'b0, pv[15:0]}; end
      default: begin
        if (b == 8'h00) return {1'b1, a, 8'hFF};
        if (o == 2'b10) begin q = ua / ub; r = ua % ub; end
        else            begin q = sa / sb; r = sa % sb; end
        qv = q;
        rv = r;
        return {1'b0, rv[7:0], qv[7:0]};
      end
    endcase
  endfunction

  // Drives start now; glitch >= 0 re-pulses start (random operands) after that many CALC edges.
  task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input int glitch);
    logic [16:0] exp;
    int          lat, bcnt;
    bit          seen;
    exp   = model(o, a, b);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op    = 2'($urandom);
    src_a = 8'($urandom);
    src_b = 8'($urandom);
    lat   = 0;
    bcnt  = busy ? 1 : 0;
    seen  = 1'b0;
    while (!seen && lat < 20) begin
      start = (lat == glitch);
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check($sformatf("done_seen op%0d %h/%h", o, a, b), 32'(seen), 32'd1);
    check($sformatf("latency op%0d %h/%h", o, a, b), lat, 9);
    check($sformatf("busy_cycles op%0d %h/%h", o, a, b), bcnt, 9);
    check($sformatf("hi op%0d %h/%h", o, a, b), 32'(hi), 32'(exp[15:8]));
    check($sformatf("lo op%0d %h/%h", o, a, b), 32'(lo), 32'(exp[7:0]));
    check($sformatf("dz op%0d %h/%h", o, a, b), 32'(div_by_zero), 32'(exp[16]));
  endtask

  // One idle cycle after done: pulses must be gone, HI/LO must hold.
  task automatic idle_check(input logic [7:0] exp_hi, input logic [7:0] exp_lo);
    @(posedge clk); #1;
    check("done_pulse_width", 32'(done), 32'd0);
    check("dz_pulse_width", 32'(div_by_zero), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("hi_hold", 32'(hi), 32'(exp_hi));
    check("lo_hold", 32'(lo), 32'(exp_lo));
  endtask

  function automatic logic [7:0] pick_operand();
    logic [7:0] v;
    case ($urandom_range(0, 7))
      0: v = 8'h00;
      1: v = 8'h01;
      2: v = 8'h7F;
      3: v = 8'h80;
      4: v = 8'hFF;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    logic [1:0] ro;
    logic [7:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    src_a = 8'h00;
    src_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dz", 32'(div_by_zero), 32'd0);
    check("reset_hi", 32'(hi), 32'd0);
    check("reset_lo", 32'(lo), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(2'b00, 8'hFF, 8'hFF, -1);
    idle_check(8'hFE, 8'h01);
    run_op(2'b01, 8'hFD, 8'h05, -1);
    run_op(2'b01, 8'h80, 8'h80, -1);
    run_op(2'b11, 8'hF9, 8'h02, -1);
    run_op(2'b10, 8'hF9, 8'h02, -1);
    run_op(2'b10, 8'h64, 8'h00, -1);
    idle_check(8'h64, 8'hFF);
    run_op(2'b11, 8'h80, 8'hFF, -1);
    run_op(2'b00, 8'h0C, 8'h0A, 2);
    run_op(2'b11, 8'h85, 8'h00, -1);

    for (int i = 0; i < 150; i++) begin
      ro = 2'($urandom);
      ra = pick_operand();
      rb = pick_operand();
      run_op(ro, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    run_op(2'b10, 8'h64, 8'h00, -1);
    op    = 2'b00;
    src_a = 8'h37;
    src_b = 8'h55;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dz", 32'(div_by_zero), 32'd0);
    check("abort_hi", 32'(hi), 32'd0);
    check("abort_lo", 32'(lo), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_abort_idle", 32'(busy), 32'd0);
    run_op(2'b10, 8'h11, 8'h03, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Iterative 8-bit multiply/divide unit for the single-cycle MIPS datapath.
- Sits directly downstream of the register bank: consumes the two register read ports as operands, and holds the result in private HI/LO registers that later MFHI/MFLO instructions return through the write-back mux.
- Runs for several cycles; drives `busy` so the control unit can stall the PC and hold the register read addresses until the unit finishes.

## Interface
- `WIDTH`, default 8: operand and HI/LO width. Must match the register-bank data width.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request an operation. Accepted only when `busy`=0.
- `op`  in  2: operation code. 00 = MULTU, 01 = MULT, 10 = DIVU, 11 = DIV.
- `src_a`  in  WIDTH: multiplicand or dividend (register bank `Read_data1`).
- `src_b`  in  WIDTH: multiplier or divisor (register bank `Read_data2`).
- `busy`  out  1: operation in progress. Defined as state ≠ IDLE.
- `done`  out  1: one-cycle pulse; HI/LO are valid in this cycle.
- `div_by_zero`  out  1: pulses together with `done` when a DIV or DIVU had `src_b`=0.
- `hi`  out  WIDTH: product upper half, or remainder.
- `lo`  out  WIDTH: product lower half, or quotient.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE:** on `start`=1:
  - latch `op`;
  - for signed ops, latch the magnitudes of `src_a`/`src_b` and record both sign bits;
  - clear the iteration counter;
  - go to CALC.
- **CALC:** runs exactly WIDTH cycles, one bit per cycle.
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract. The remainder register is WIDTH+1 bits and the quotient is shifted in from the LSB.
  - When the counter reaches WIDTH-1, go to FIX.
- **FIX:** apply sign correction, write `hi`/`lo`, set `done`=1 for the next cycle, go to IDLE.
  - MULT: negate the 2·WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ. The remainder takes the dividend's sign.
  - All negation is two's complement modulo 2^WIDTH (2^(2·WIDTH) for the product).
- **Divide by zero (DIVU or DIV, `src_b`=0):**
  - Full latency is kept.
  - Result is `lo`=all ones and `hi`=`src_a` unchanged; no sign fix on either.
  - `div_by_zero`=1 together with `done`.
- **Signed overflow:** DIV of -2^(WIDTH-1) by -1 wraps. For WIDTH=8: `lo`=0x80, `hi`=0x00, no flag.
- **`start` while `busy`=1:** ignored. Latched operands and op are not disturbed.
- **`start` in the `done` cycle:** accepted, because the state is already IDLE.
- **HI/LO hold:** values persist until the next FIX or `rst`; they are not cleared at `start`.

## Timing
- Reset value of every output is 0: `busy`, `done`, `div_by_zero`, `hi`, `lo`. State goes to IDLE and the counter to 0.
- `rst` mid-operation aborts immediately and asynchronously. No partial result is written.
- Cycle-level sequence, with `start` sampled at edge E0:
  - `busy` rises after E0.
  - CALC occupies edges E1..E_WIDTH.
  - FIX is at edge E_WIDTH+1, which writes `hi`/`lo` and raises `done` and `div_by_zero`.
  - `busy` falls at that same edge.
- Latency from `start` edge to `done` is WIDTH+1 cycles: 9 for WIDTH=8.
- `busy` is high for exactly WIDTH+1 cycles.
- Maximum throughput is one operation every WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- **Package `mdu_pkg`:**
  - `op` encodings: `MDU_MULTU`, `MDU_MULT`, `MDU_DIVU`, `MDU_DIV`;
  - state enum: IDLE, CALC, FIX;
  - counter width, $clog2(WIDTH).
- **Sub-module `mdu_negate`:** combinational, parameterised-width two's-complement conditional negate (`in`, `neg` → `out`). Instantiated for operand magnitudes and for the sign fix of product, quotient and remainder.
- **Everything else** (FSM, counter, accumulator and remainder datapath) lives in a single module.

## Test plan
- MULTU `src_a`=0xFF, `src_b`=0xFF → `hi`=0xFE, `lo`=0x01. `done` is exactly 9 cycles after the `start` edge and `busy` is high for 9 cycles.
- MULT 0xFD (-3) × 0x05 → `hi`=0xFF, `lo`=0xF1 (-15). Then MULT 0x80 × 0x80 → `hi`=0x40, `lo`=0x00.
- DIV 0xF9 (-7) ÷ 0x02 → `lo`=0xFD (-3), `hi`=0xFF (-1). DIVU 0xF9 ÷ 0x02 → `lo`=0x7C, `hi`=0x01.
- DIVU 0x64 ÷ 0x00 → `lo`=0xFF, `hi`=0x64, `div_by_zero`=1 for one cycle. DIV 0x80 ÷ 0xFF → `lo`=0x80, `hi`=0x00, `div_by_zero`=0.
- Pulse `start` again at cycle 3 of a MULTU 0x0C×0x0A with different operands → ignored, result `hi`=0x00, `lo`=0x78. Then a `start` in the `done` cycle → accepted.
- Assert `rst` during cycle 4 of CALC → all outputs 0 immediately. After release, DIVU 0x11 ÷ 0x03 → `lo`=0x05, `hi`=0x02.
